// File: rtl/mask_stream_gen.sv
// mask_stream_gen: thresholds active raster pixels against a band latched at start-of-frame, streams in-band coords, counts per frame.
// latency: 2 cycles input -> x/y/valid/mask; tabulate + count 3 cycles after the last-pixel input cycle.
// backpressure: none; one pixel per cycle in and out, downstream must always accept.
// Optional feature macro: MASK_STREAM_ROI_EN (adds an inclusive ROI window latched at start-of-frame).
// Ports:
//   clk_in, rst_in (sync, active-high)
//   hcount_in/vcount_in/data_valid_in/pixel_in : raster stream
//   lower_bound_in/upper_bound_in              : inclusive band, sampled at start-of-frame
//   x_out/y_out/valid_out/mask_out             : per-pixel result, 2-cycle latency
//   tabulate_out/count_valid_out/pixel_count_out : end-of-frame pulse and last frame's in-band count
module mask_stream_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = 21
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              data_valid_in,
  input  logic [7:0]        pixel_in,
  input  logic [7:0]        lower_bound_in,
  input  logic [7:0]        upper_bound_in,
`ifdef MASK_STREAM_ROI_EN
  input  logic [10:0]       roi_x_min_in,
  input  logic [10:0]       roi_x_max_in,
  input  logic [9:0]        roi_y_min_in,
  input  logic [9:0]        roi_y_max_in,
`endif
  output logic [10:0]       x_out,
  output logic [9:0]        y_out,
  output logic              valid_out,
  output logic              mask_out,
  output logic              tabulate_out,
  output logic [CNT_W-1:0]  pixel_count_out,
  output logic              count_valid_out
);

  localparam logic [10:0]      LP_H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]       LP_V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    IN_FRAME = 2'd1,
    DONE     = 2'd2
  } state_t;

  // Input-side classification
  logic w_active, w_sof, w_eof;
  assign w_active = data_valid_in && (hcount_in <= LP_H_LAST) && (vcount_in <= LP_V_LAST);
  assign w_sof    = w_active && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_eof    = w_active && (hcount_in == LP_H_LAST) && (vcount_in == LP_V_LAST);

  // Thresholds are captured on the same edge that loads the SOF pixel into
  // stage 1, so the SOF pixel itself is compared against the new band.
  logic [7:0] r_lo, r_hi;
`ifdef MASK_STREAM_ROI_EN
  logic [10:0] r_x_min, r_x_max;
  logic [9:0]  r_y_min, r_y_max;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_lo <= 8'd0;
      r_hi <= 8'd0;
`ifdef MASK_STREAM_ROI_EN
      r_x_min <= 11'd0;
      r_x_max <= 11'd0;
      r_y_min <= 10'd0;
      r_y_max <= 10'd0;
`endif
    end else if (w_sof) begin
      r_lo <= lower_bound_in;
      r_hi <= upper_bound_in;
`ifdef MASK_STREAM_ROI_EN
      r_x_min <= roi_x_min_in;
      r_x_max <= roi_x_max_in;
      r_y_min <= roi_y_min_in;
      r_y_max <= roi_y_max_in;
`endif
    end
  end

  // Stage 1: registered inputs
  logic        r_s1_active, r_s1_sof, r_s1_eof;
  logic [10:0] r_s1_x;
  logic [9:0]  r_s1_y;
  logic [7:0]  r_s1_pix;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_active <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_eof    <= 1'b0;
      r_s1_x      <= 11'd0;
      r_s1_y      <= 10'd0;
      r_s1_pix    <= 8'd0;
    end else begin
      r_s1_active <= w_active;
      r_s1_sof    <= w_sof;
      r_s1_eof    <= w_eof;
      r_s1_x      <= hcount_in;
      r_s1_y      <= vcount_in;
      r_s1_pix    <= pixel_in;
    end
  end

  // Compare on stage-1 data; lo > hi naturally yields no match.
  logic w_in_band, w_mask;
`ifdef MASK_STREAM_ROI_EN
  logic w_in_roi;
  assign w_in_roi = (r_s1_x >= r_x_min) && (r_s1_x <= r_x_max) &&
                    (r_s1_y >= r_y_min) && (r_s1_y <= r_y_max);
  assign w_in_band = (r_s1_pix >= r_lo) && (r_s1_pix <= r_hi) && w_in_roi;
`else
  assign w_in_band = (r_s1_pix >= r_lo) && (r_s1_pix <= r_hi);
`endif
  assign w_mask = r_s1_active && w_in_band;

  // Stage 2: per-pixel outputs; coordinates hold between in-band pixels.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      mask_out  <= 1'b0;
      x_out     <= 11'd0;
      y_out     <= 10'd0;
    end else begin
      valid_out <= w_mask;
      mask_out  <= w_mask;
      if (w_mask) begin
        x_out <= r_s1_x;
        y_out <= r_s1_y;
      end
    end
  end

  // Frame counter: a fresh frame starts at 0 or 1 depending on the SOF pixel;
  // increments stop at all-ones rather than wrapping.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_start, w_cnt_next;
  assign w_cnt_start = w_mask ? LP_CNT_ONE : '0;
  assign w_cnt_next  = (w_mask && (r_cnt != '1)) ? (r_cnt + LP_CNT_ONE) : r_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= WAIT_SOF;
      r_cnt           <= '0;
      tabulate_out    <= 1'b0;
      count_valid_out <= 1'b0;
      pixel_count_out <= '0;
    end else begin
      tabulate_out    <= 1'b0;
      count_valid_out <= 1'b0;
      case (r_state)
        WAIT_SOF: begin
          if (r_s1_sof) begin
            r_state <= IN_FRAME;
            r_cnt   <= w_cnt_start;
          end
        end
        IN_FRAME: begin
          if (r_s1_sof) begin
            // Frame restarted early: drop the partial count silently.
            r_cnt <= w_cnt_start;
          end else begin
            r_cnt <= w_cnt_next;
            if (r_s1_eof) r_state <= DONE;
          end
        end
        DONE: begin
          tabulate_out    <= 1'b1;
          count_valid_out <= 1'b1;
          pixel_count_out <= r_cnt;
          // A back-to-back stream may already have the next SOF in stage 1.
          if (r_s1_sof) begin
            r_state <= IN_FRAME;
            r_cnt   <= w_cnt_start;
          end else begin
            r_state <= WAIT_SOF;
          end
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_stream_gen.sv
// tb_mask_stream_gen: directed frame-level vector table plus hand-written latency/tabulate sequences.
// latency: expects outputs 2 cycles and tabulate 3 cycles after the input cycle.
// backpressure: none; the bench drives one pixel per cycle.
module tb_mask_stream_gen;

  localparam int H  = 16;
  localparam int V  = 16;
  localparam int CW = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          data_valid_in;
  logic [7:0]    pixel_in;
  logic [7:0]    lower_bound_in;
  logic [7:0]    upper_bound_in;
  logic [10:0]   x_out;
  logic [9:0]    y_out;
  logic          valid_out;
  logic          mask_out;
  logic          tabulate_out;
  logic [CW-1:0] pixel_count_out;
  logic          count_valid_out;

  mask_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_in(data_valid_in), .pixel_in(pixel_in),
    .lower_bound_in(lower_bound_in), .upper_bound_in(upper_bound_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .mask_out(mask_out),
    .tabulate_out(tabulate_out), .pixel_count_out(pixel_count_out),
    .count_valid_out(count_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_vld = 0;
  int mon_tab = 0;
  int mon_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor on the falling edge, well away from the active edge.
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) mon_vld++;
    if (tabulate_out === 1'b1) begin
      mon_tab++;
      mon_cnt = int'(pixel_count_out);
    end
    if (tabulate_out === 1'b1 || count_valid_out === 1'b1) begin
      n_cmp++;
      if (tabulate_out !== count_valid_out) begin
        n_bad++;
        $display("FAIL count_valid_align: count_valid_out=%b tabulate_out=%b", count_valid_out, tabulate_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic [7:0] v, input logic dv);
    hcount_in     = 11'(x);
    vcount_in     = 10'(y);
    pixel_in      = v;
    data_valid_in = dv;
  endtask

  // kind: 0 full frame, 1 reset pulse at line 'stop', 2 jump back (stop sending at 'stop'),
  //       3 bounds changed to lo2/hi2 at line 'stop'. pat 1: pixel = x*16+y.
  typedef struct {
    int lo, hi, pat, base, spx, spy, spv, kind, stop, lo2, hi2;
    int exp_tab, exp_cnt, exp_vld;
  } vec_t;

  function automatic logic [7:0] pval(input vec_t v, input int x, input int y);
    if (x == v.spx && y == v.spy) return 8'(v.spv);
    if (v.pat == 1) return 8'(x * 16 + y);
    return 8'(v.base);
  endfunction

  task automatic send_frame(input vec_t v);
    lower_bound_in = 8'(v.lo);
    upper_bound_in = 8'(v.hi);
    for (int y = 0; y < V; y++) begin
      if (v.kind == 2 && y == v.stop) break;
      if (v.kind == 1 && y == v.stop) begin
        data_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
      end
      if (v.kind == 3 && y == v.stop) begin
        lower_bound_in = 8'(v.lo2);
        upper_bound_in = 8'(v.hi2);
      end
      for (int x = 0; x < H; x++) begin
        drive(x, y, pval(v, x, y), 1'b1);
        tick();
      end
      // Off-screen but valid sample, value inside the requested band.
      drive(H, y, lower_bound_in, 1'b1);
      tick();
    end
    data_valid_in = 1'b0;
    repeat (6) tick();
  endtask

  vec_t vecs[10];

  initial begin
    //          lo   hi  pat base spx spy spv kind stop lo2 hi2 tab  cnt  vld
    vecs[0] = '{ 50, 150, 0, 100, -1, -1,   0, 0,  0,  0,  0,  1, 255, 256};
    vecs[1] = '{200, 100, 0, 100, -1, -1,   0, 0,  0,  0,  0,  1,   0,   0};
    vecs[2] = '{150, 150, 0,   0, 10,  5, 150, 0,  0,  0,  0,  1,   1,   1};
    vecs[3] = '{150, 150, 0,   0, 10,  5, 151, 0,  0,  0,  0,  1,   0,   0};
    vecs[4] = '{  0, 255, 0,   7, -1, -1,   0, 3,  8,  0,  0,  1, 255, 256};
    vecs[5] = '{  0,   0, 0,   7, -1, -1,   0, 0,  0,  0,  0,  1,   0,   0};
    vecs[6] = '{  0, 255, 0,   1, -1, -1,   0, 1,  8,  0,  0,  0,   0, 128};
    vecs[7] = '{ 16,  47, 1,   0, -1, -1,   0, 0,  0,  0,  0,  1,  32,  32};
    vecs[8] = '{  0, 255, 1,   0, -1, -1,   0, 2, 10,  0,  0,  0,   0, 160};
    vecs[9] = '{  0,  63, 1,   0, -1, -1,   0, 0,  0,  0,  0,  1,  64,  64};

    rst_in = 1'b1;
    drive(0, 0, 8'd0, 1'b0);
    lower_bound_in = 8'd0;
    upper_bound_in = 8'd0;
    repeat (3) tick();
    check("rst_valid", int'(valid_out), 0);
    check("rst_mask", int'(mask_out), 0);
    check("rst_tab", int'(tabulate_out), 0);
    check("rst_cvld", int'(count_valid_out), 0);
    check("rst_cnt", int'(pixel_count_out), 0);
    check("rst_xy", int'({x_out, y_out}), 0);
    rst_in = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      mon_vld = 0;
      mon_tab = 0;
      mon_cnt = -1;
      send_frame(vecs[i]);
      check($sformatf("v%0d_tab", i), mon_tab, vecs[i].exp_tab);
      check($sformatf("v%0d_vld", i), mon_vld, vecs[i].exp_vld);
      if (vecs[i].exp_tab == 1) check($sformatf("v%0d_cnt", i), mon_cnt, vecs[i].exp_cnt);
    end

    // Hand sequence: exact latency, coordinate hold, gating, tabulate timing.
    lower_bound_in = 8'd0;
    upper_bound_in = 8'd255;
    drive(0, 0, 8'd5, 1'b1);
    tick();
    check("lat_t1_valid", int'(valid_out), 0);
    drive(0, 0, 8'd0, 1'b0);
    tick();
    check("lat_t2_valid", int'(valid_out), 1);
    check("lat_t2_xy", int'({x_out, y_out}), 0);
    drive(3, 2, 8'd5, 1'b1);
    tick();
    check("lat_t3_valid", int'(valid_out), 0);
    drive(H + 4, 2, 8'd5, 1'b1);
    tick();
    check("p32_valid", int'(valid_out), 1);
    check("p32_x", int'(x_out), 3);
    check("p32_y", int'(y_out), 2);
    drive(4, 4, 8'd5, 1'b0);
    tick();
    check("offscreen_mask", int'(mask_out), 0);
    check("hold_x", int'(x_out), 3);
    drive(15, 15, 8'd5, 1'b1);
    tick();
    check("dv_low_valid", int'(valid_out), 0);
    drive(0, 0, 8'd0, 1'b0);
    tick();
    check("last_valid", int'(valid_out), 1);
    check("last_xy", int'({x_out, y_out}), int'({11'd15, 10'd15}));
    check("last_no_tab", int'(tabulate_out), 0);
    tick();
    check("tab_t3", int'(tabulate_out), 1);
    check("cvld_t3", int'(count_valid_out), 1);
    check("cnt_t3", int'(pixel_count_out), 3);
    check("valid_t3", int'(valid_out), 0);
    tick();
    check("tab_t4", int'(tabulate_out), 0);
    check("cnt_hold", int'(pixel_count_out), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mask_stream_gen.md
Name: mask_stream_gen

Overview:
- Upstream feeder for the centroid stage.
- Consumes the raster pixel stream (hcount/vcount plus one selected 8-bit colour channel) and thresholds each active pixel against a band.
- Emits per-pixel coordinates with a valid strobe for in-band pixels, and a single-cycle tabulate pulse once per complete frame.
- Also reports the in-band pixel count of the last completed frame for debug/gating.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
CNT_W, 21, width of per-frame pixel counter (saturating)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
hcount_in  input  11  horizontal position of incoming pixel
vcount_in  input  10  vertical position of incoming pixel
data_valid_in  input  1  incoming pixel/position valid this cycle
pixel_in  input  8  selected channel value
lower_bound_in  input  8  inclusive lower threshold
upper_bound_in  input  8  inclusive upper threshold
x_out  output  11  x of in-band pixel
y_out  output  10  y of in-band pixel
valid_out  output  1  x_out/y_out hold an in-band active pixel
mask_out  output  1  raw mask bit for every active pixel (display overlay)
tabulate_out  output  1  one-cycle end-of-frame pulse
pixel_count_out  output  CNT_W  in-band count of last completed frame
count_valid_out  output  1  pulses with tabulate_out; pixel_count_out updated

Behaviour:
- Reset: all outputs 0; pipeline cleared; FSM to WAIT_SOF; latched thresholds 0.
- Active pixel: data_valid_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE. Non-active inputs never produce valid_out or mask_out.
- Pipeline: 2 stages.
  - Stage 1 registers the inputs.
  - Stage 2 compares and drives the outputs.
  - valid_out, mask_out, x_out and y_out appear exactly 2 cycles after the input cycle.
- Compare rule: mask = lo <= pixel <= hi, unsigned, inclusive, using the thresholds latched at start-of-frame. If lo > hi, mask is always 0.
- valid_out = stage-1 active && mask. x_out/y_out are updated only when valid_out=1 and hold their value otherwise.
- FSM states:
  - WAIT_SOF: ignore the stream for tabulation. valid_out/mask_out still follow the rules above using the currently latched thresholds. Leave when an active pixel at (0,0) arrives: latch lower/upper bounds that same cycle (they are used for that pixel too), clear the frame counter, go to IN_FRAME.
  - IN_FRAME:
    - Count in-band pixels; the counter saturates at 2^CNT_W-1 and does not wrap.
    - An active pixel at (H_ACTIVE-1, V_ACTIVE-1) moves the FSM to DONE.
    - An active pixel at (0,0) seen while in IN_FRAME (frame restarted without reaching the end) discards the count, re-latches the thresholds and restarts IN_FRAME. No tabulate is emitted.
  - DONE: one cycle. On the following cycle, tabulate_out=1 and count_valid_out=1, and pixel_count_out is loaded with the final count (including the last pixel if it was in-band). Then return to WAIT_SOF.
- Tabulate timing: tabulate_out asserts 3 cycles after the last-pixel input cycle, i.e. one cycle after the last pixel's valid_out slot. It is never coincident with valid_out from the same frame.
- Exactly one tabulate pulse per complete frame.
- Reset mid-frame: the partial frame is abandoned. No tabulate is emitted until a full frame from (0,0) has been seen.
- data_valid_in low: the pipeline advances with invalid data. No stall or backpressure. The downstream consumer must accept one pixel per cycle.
- Threshold ports may change at any time. Changes take effect only at the next start-of-frame.

Optional Feature:
MASK_STREAM_ROI_EN
- Defined: adds inputs roi_x_min_in[10:0], roi_x_max_in[10:0], roi_y_min_in[9:0] and roi_y_max_in[9:0].
  - These are latched at start-of-frame together with the thresholds.
  - A pixel outside the inclusive window forces mask=0, so it is neither counted nor emitted.
  - A window with min > max masks everything.
- Undefined: the ports are absent and the whole active area is considered.

Test Plan:
- All pixels 100, bounds [50,150], 1280x720 frame -> valid_out on every active pixel 2 cycles after input; tabulate_out once, 3 cycles after (1279,719); pixel_count_out=921600.
- Bounds lo=200, hi=100 -> no valid_out for the whole frame; tabulate_out still pulses; pixel_count_out=0.
- Pixel 150 at (10,5) with bounds [150,150] and all others 0 -> single valid_out with x_out=10, y_out=5; count=1. Pixel 151 -> no valid_out.
- Bounds changed mid-frame from [0,255] to [0,0] -> current frame still counts all pixels (921600); next frame uses the new bounds.
- rst_in pulsed at line 300, stream continues -> no tabulate for that frame; the next full frame produces exactly one tabulate.
- Stream jumps back to (0,0) at line 400 -> no tabulate; the next complete frame tabulates with only its own count.
